// File: rtl/vfd_scan_if.sv
// vfd_scan bus: MCU grid/segment port lines, decay tick, and the frame-buffer read port.
// The master side is the MCU/overlay logic. The slave side is the capture stage.
interface vfd_scan_if #(
   parameter int ADDR_W = 3,
   parameter int SEG_W  = 16
);
   localparam int NG = 2**ADDR_W;

   logic              tick;
   logic [NG-1:0]     grid;
   logic [SEG_W-1:0]  seg;
   logic [ADDR_W-1:0] rd_addr;
   logic [SEG_W-1:0]  rd_data;
   logic [NG-1:0]     lit;
   logic              changed;

   modport master (output tick, grid, seg, rd_addr, input  rd_data, lit, changed);
   modport slave  (input  tick, grid, seg, rd_addr, output rd_data, lit, changed);
endinterface

// File: rtl/vfd_scan.sv
// vfd_scan: filters nibble-update transients off VFD grid/segment ports into a per-grid frame buffer.
// Optional phosphor persistence (per-row decay on tick) is enabled by defining VFD_DECAY_EN.
module vfd_scan #(
   parameter int ADDR_W  = 3,
   parameter int SEG_W   = 16,
   parameter int STABLE  = 4,
   parameter int DECAY_W = 4,
   parameter int PERSIST = 8
) (
   input  logic      clk,
   input  logic      reset,
   vfd_scan_if.slave bus
);
   localparam int NG = 2**ADDR_W;
   localparam logic [3:0] STABLE_C = 4'(STABLE);

   typedef enum logic [1:0] {
      ST_BLANK  = 2'd0,
      ST_SETTLE = 2'd1,
      ST_LOCK   = 2'd2
   } state_t;

   state_t            state_r;
   logic [NG-1:0]     s_grid_r;
   logic [SEG_W-1:0]  s_seg_r;
   logic [3:0]        cnt_r;
   logic [SEG_W-1:0]  row_r      [NG];
   logic [SEG_W-1:0]  row_next_s [NG];
   logic [NG-1:0]     lit_next_s;
   logic              diff_s;
   logic              commit_s;
   logic              in_change_s;
   logic [SEG_W-1:0]  rd_data_r;
   logic [NG-1:0]     lit_r;
   logic              diff_r;
   logic              changed_r;

   function automatic logic [3:0] sat_inc(input logic [3:0] v);
      logic [3:0] r;
      if (v >= STABLE_C) r = STABLE_C;
      else               r = v + 4'd1;
      return r;
   endfunction

   assign in_change_s = ({bus.grid, bus.seg} != {s_grid_r, s_seg_r});
   // Commit on the same edge the FSM enters (or stays in) LOCK, so the write lands at edge STABLE+2.
   assign commit_s    = (state_r != ST_BLANK) && (s_grid_r != {NG{1'b0}}) && (cnt_r == STABLE_C);

   // Input capture and stability counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s_grid_r <= {NG{1'b0}};
         s_seg_r  <= {SEG_W{1'b0}};
         cnt_r    <= 4'd0;
      end else begin
         s_grid_r <= bus.grid;
         s_seg_r  <= bus.seg;
         if (in_change_s) cnt_r <= 4'd0;
         else             cnt_r <= sat_inc(cnt_r);
      end
   end

   // Filter FSM: BLANK while no grid is strobed, SETTLE while the code is young, LOCK once stable.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= ST_BLANK;
      end else begin
         case (state_r)
            ST_BLANK: begin
               if (s_grid_r != {NG{1'b0}}) state_r <= ST_SETTLE;
               else                        state_r <= ST_BLANK;
            end
            ST_SETTLE: begin
               if (s_grid_r == {NG{1'b0}})  state_r <= ST_BLANK;
               else if (cnt_r == STABLE_C) state_r <= ST_LOCK;
               else                        state_r <= ST_SETTLE;
            end
            ST_LOCK: begin
               if (s_grid_r == {NG{1'b0}})  state_r <= ST_BLANK;
               else if (cnt_r != STABLE_C) state_r <= ST_SETTLE;
               else                        state_r <= ST_LOCK;
            end
            default: state_r <= ST_BLANK;
         endcase
      end
   end

`ifdef VFD_DECAY_EN
   localparam logic [DECAY_W-1:0] PERSIST_C = DECAY_W'(PERSIST);
   localparam logic [DECAY_W-1:0] PC_ONE    = {{(DECAY_W-1){1'b0}}, 1'b1};

   logic [DECAY_W-1:0] pc_r      [NG];
   logic [DECAY_W-1:0] pc_next_s [NG];

   // Next row/pc: a commit reloads and beats a coincident tick; the 1->0 decay step blanks the row.
   always_comb begin
      for (int i = 0; i < NG; i++) begin
         row_next_s[i] = row_r[i];
         pc_next_s[i]  = pc_r[i];
         if (commit_s && s_grid_r[i]) begin
            row_next_s[i] = s_seg_r;
            pc_next_s[i]  = PERSIST_C;
         end else if (bus.tick && (pc_r[i] != {DECAY_W{1'b0}})) begin
            pc_next_s[i] = pc_r[i] - PC_ONE;
            if (pc_r[i] == PC_ONE) row_next_s[i] = {SEG_W{1'b0}};
            else                   row_next_s[i] = row_r[i];
         end else begin
            pc_next_s[i] = pc_r[i];
         end
      end
   end

   // Persistence counters.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NG; i++) pc_r[i] <= {DECAY_W{1'b0}};
      end else begin
         for (int i = 0; i < NG; i++) pc_r[i] <= pc_next_s[i];
      end
   end
`else
   logic unused_tick_s;
   assign unused_tick_s = bus.tick;

   // Next row: rows hold until recommitted.
   always_comb begin
      for (int i = 0; i < NG; i++) begin
         if (commit_s && s_grid_r[i]) row_next_s[i] = s_seg_r;
         else                         row_next_s[i] = row_r[i];
      end
   end
`endif

   // Row occupancy and any-row-changed detection from the next-state rows.
   always_comb begin
      diff_s = 1'b0;
      for (int i = 0; i < NG; i++) begin
         lit_next_s[i] = |row_next_s[i];
         if (row_next_s[i] != row_r[i]) diff_s = 1'b1;
         else                           diff_s = diff_s;
      end
   end

   // Frame buffer rows.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NG; i++) row_r[i] <= {SEG_W{1'b0}};
      end else begin
         for (int i = 0; i < NG; i++) row_r[i] <= row_next_s[i];
      end
   end

   // Registered outputs; read is before-write, and changed trails the row write by one edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_data_r <= {SEG_W{1'b0}};
         lit_r     <= {NG{1'b0}};
         diff_r    <= 1'b0;
         changed_r <= 1'b0;
      end else begin
         rd_data_r <= row_r[bus.rd_addr];
         lit_r     <= lit_next_s;
         diff_r    <= diff_s;
         changed_r <= diff_r;
      end
   end

   assign bus.rd_data = rd_data_r;
   assign bus.lit     = lit_r;
   assign bus.changed = changed_r;
endmodule

// File: tb/tb_vfd_scan.sv
// Scoreboard bench for vfd_scan: a hold-duration reference model queues expected outputs per edge,
// and a negedge monitor pops and compares them. Decay checks follow VFD_DECAY_EN.
module tb_vfd_scan;
   localparam int ADDR_W  = 3;
   localparam int SEG_W   = 16;
   localparam int STABLE  = 4;
   localparam int PERSIST = 8;
   localparam int NG      = 8;

   typedef struct packed {
      logic [15:0] rd;
      logic [7:0]  lit;
      logic        chg;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   vfd_scan_if #(.ADDR_W(ADDR_W), .SEG_W(SEG_W)) bus ();

   vfd_scan #(
      .ADDR_W(ADDR_W), .SEG_W(SEG_W), .STABLE(STABLE), .DECAY_W(4), .PERSIST(PERSIST)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Model state: frame rows, persistence, last captured code and how many edges it has been held.
   logic [15:0] mrow [NG];
`ifdef VFD_DECAY_EN
   int          mpc  [NG];
`endif
   logic [7:0]  prev_g;
   logic [15:0] prev_s;
   int          run;
   logic        chg_pend;

   logic [7:0]  cur_g;
   logic [15:0] cur_s;
   logic        cur_tick;
   logic [2:0]  cur_addr;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NG; i++) begin
         mrow[i] = 16'h0000;
`ifdef VFD_DECAY_EN
         mpc[i] = 0;
`endif
      end
      prev_g   = 8'h00;
      prev_s   = 16'h0000;
      run      = 0;
      chg_pend = 1'b0;
   endtask

   // One edge of the reference: a code held for at least STABLE+1 captures is written from then on.
   task automatic model_step();
      exp_t        e;
      logic        commit;
      logic        any_chg;
      logic [15:0] old;
      commit  = (run >= STABLE + 1) && (prev_g != 8'h00);
      e.rd    = mrow[cur_addr];
      any_chg = 1'b0;
      for (int i = 0; i < NG; i++) begin
         old = mrow[i];
         if (commit && prev_g[i]) begin
            mrow[i] = prev_s;
`ifdef VFD_DECAY_EN
            mpc[i] = PERSIST;
`endif
         end
`ifdef VFD_DECAY_EN
         else if (cur_tick && mpc[i] > 0) begin
            mpc[i] = mpc[i] - 1;
            if (mpc[i] == 0) mrow[i] = 16'h0000;
         end
`endif
         if (mrow[i] != old) any_chg = 1'b1;
         e.lit[i] = (mrow[i] != 16'h0000);
      end
      e.chg    = chg_pend;
      chg_pend = any_chg;
      if (cur_g == prev_g && cur_s == prev_s) begin
         if (run < 1000) run++;
      end else begin
         run = 1;
      end
      prev_g = cur_g;
      prev_s = cur_s;
      exp_q.push_back(e);
   endtask

   task automatic apply();
      bus.grid    = cur_g;
      bus.seg     = cur_s;
      bus.tick    = cur_tick;
      bus.rd_addr = cur_addr;
   endtask

   // Hold one code for len edges; tick_mode 0 = none, 1 = every other edge, 2 = random.
   task automatic run_seg(input logic [7:0] g, input logic [15:0] s, input int len, input int tick_mode);
      for (int k = 0; k < len; k++) begin
         cur_g    = g;
         cur_s    = s;
         cur_tick = (tick_mode == 1) ? 1'(k % 2) :
                    (tick_mode == 2) ? ($urandom_range(3) == 0) : 1'b0;
         cur_addr = 3'($urandom_range(NG - 1));
         apply();
         @(posedge clk);
         model_step();
         #1;
      end
   endtask

   // Monitor: pop the expected response for the latest edge and compare.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rd_data", 32'(bus.rd_data), 32'(e.rd));
            check("lit",     32'(bus.lit),     32'(e.lit));
            check("changed", 32'(bus.changed), 32'(e.chg));
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  rg;
      logic [15:0] rs;
      cur_g = 8'h00; cur_s = 16'h0000; cur_tick = 1'b0; cur_addr = 3'd0;
      apply();
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("reset_rd_data", 32'(bus.rd_data), 32'h0);
      check("reset_lit",     32'(bus.lit),     32'h0);
      check("reset_changed", 32'(bus.changed), 32'h0);
      check("reset_state",   32'(dut.state_r), 32'h0);
      #2 reset = 1'b1;

      run_seg(8'h00, 16'h0000, 4,  0);
      run_seg(8'h04, 16'hA5A5, 8,  0);
      run_seg(8'h04, 16'hFFFF, 3,  0);
      run_seg(8'h01, 16'hA5A5, 8,  0);
      run_seg(8'h81, 16'h00F0, 7,  0);
      run_seg(8'h08, 16'h3C3C, 7,  0);
      run_seg(8'h00, 16'h0000, 24, 1);
      run_seg(8'h20, 16'h5A5A, 14, 1);
      run_seg(8'h00, 16'h0000, 6,  0);
      run_seg(8'h20, 16'h5A5A, 5,  0);
      run_seg(8'h20, 16'h5A5B, 6,  0);

      for (int n = 0; n < 70; n++) begin
         case ($urandom_range(3))
            0:       rg = 8'h00;
            1:       rg = 8'(1 << $urandom_range(7));
            default: rg = 8'($urandom);
         endcase
         rs = 16'($urandom);
         run_seg(rg, rs, $urandom_range(1, 12), 2);
      end

      // Asynchronous reset in the middle of LOCK, between clock edges.
      run_seg(8'h40, 16'hBEEF, 10, 0);
      #1 reset = 1'b0;
      #1;
      check("async_rd_data", 32'(bus.rd_data), 32'h0);
      check("async_lit",     32'(bus.lit),     32'h0);
      check("async_changed", 32'(bus.changed), 32'h0);
      check("async_state",   32'(dut.state_r), 32'h0);
      exp_q.delete();
      model_reset();
      cur_g = 8'h00; cur_s = 16'h0000; cur_tick = 1'b0;
      apply();
      @(posedge clk);
      #3 reset = 1'b1;
      run_seg(8'h02, 16'h1111, 10, 2);
      run_seg(8'h00, 16'h0000, 4,  0);

      repeat (3) @(negedge clk);
      check("scoreboard_drain", 32'(exp_q.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/vfd_scan.md
# vfd_scan

Display-capture stage downstream of the uCOM-43 core. It takes the multiplexed VFD grid strobes and segment lines driven on the MCU output ports and filters out the transient codes produced by nibble-at-a-time port updates. It rebuilds a static per-grid segment frame buffer with phosphor-style persistence, which the video/overlay logic reads through a synchronous read port.

## Interface
- `ADDR_W`, 3: grid index width; grid count `NG = 2**ADDR_W`.
- `SEG_W`, 16: segment lines per grid.
- `STABLE`, 4: cycles the grid/segment input must stay unchanged before it is committed. Allowed range 1..15.
- `DECAY_W`, 4: width of the per-row persistence counter.
- `PERSIST`, 8: persistence reload value, in `tick` periods. Must be ≥1.

Ports:
- `clk` in 1: system clock; same clock as the MCU.
- `reset` in 1: asynchronous, active-low (0 = in reset).
- `tick` in 1: single-cycle decay timebase strobe.
- `grid` in NG: grid strobes, active-high, taken from the MCU port outputs.
- `seg` in SEG_W: segment lines, active-high.
- `rd_addr` in ADDR_W: frame-buffer read row.
- `rd_data` out SEG_W: registered row contents.
- `lit` out NG: bit i is 1 when row i is nonzero (OR-reduce of registered rows).
- `changed` out 1: one-cycle pulse after any row content changes.

## Operation
- **Input register.** `s_grid`/`s_seg` capture `grid`/`seg` on every edge.
- **Stability counter `cnt`.**
  - If `{grid,seg} != {s_grid,s_seg}`, `cnt` clears to 0.
  - Otherwise `cnt` increments, saturating at STABLE.
- **Filter FSM:**
  - BLANK: `s_grid == 0`. No commits. Go to SETTLE when `s_grid` becomes nonzero.
  - SETTLE: `cnt < STABLE`. Go to LOCK when `cnt == STABLE`. Go to BLANK when `s_grid == 0`.
  - LOCK: commit every cycle. Go to SETTLE on any input change (`cnt` cleared). Go to BLANK when `s_grid == 0`.
- **Commit (LOCK only).** For every i with `s_grid[i] == 1`:
  - row[i] is replaced by `s_seg`.
  - Persistence counter pc[i] is reloaded to PERSIST.
  - When several grid bits are set at once, all selected rows receive the same `s_seg`.
- **Decay.** On `tick`, each row not being committed that cycle with `pc[i] != 0` decrements `pc[i]`.
  - When `pc[i]` goes from 1 to 0, row[i] clears to 0 on the same edge.
  - If reload and `tick` hit the same row in the same cycle, the reload wins.
  - `pc` stays at 0; it does not wrap.
- **Read port.** `rd_data <= row[rd_addr]` on each edge, read-before-write: a same-cycle commit is visible on the following read.
- **`changed`.** Registered OR over rows of (next row value != current row value). It pulses for each cycle in which any row changed.
- **Reset (asynchronous, any state, including mid-commit):**
  - rows, pc, `rd_data`, `lit`, `changed`, `cnt`, `s_grid`, `s_seg` = 0.
  - FSM = BLANK.

## Timing
- Input change at edge 0, then held: `s_*` updates at edge 1, `cnt` reaches STABLE at edge STABLE+1, and the row is written at edge STABLE+2.
- `lit` follows the row on the same edge. `changed` pulses on the edge after the row write. `rd_data` for that row shows the new value one edge after the row write.
- Steady LOCK re-commits identical data each cycle. `changed` does not pulse for this.
- A glitch lasting fewer than STABLE+1 cycles is never committed.
- Decay: a row last committed before tick #1 clears on tick #PERSIST.

## Configuration
- `VFD_DECAY_EN` defined: persistence counters and decay operate as above.
- `VFD_DECAY_EN` undefined: pc and `tick` logic are removed, and `tick` is ignored. A row keeps its last committed value until it is committed again or reset.

## Test plan
- Reset release with `grid=0`, `seg=0` → all outputs 0, FSM BLANK, no `changed`.
- STABLE=4: `grid=8'h04`, `seg=16'hA5A5` held from edge 0 → row2 = A5A5 and `lit=8'h04` at edge 6, `changed` at edge 7; `rd_addr=2` returns A5A5.
- `seg` toggles to 16'hFFFF for 3 cycles, then back to A5A5 with `grid=8'h01` → row0 = A5A5 only; FFFF never stored.
- `grid=8'h81`, `seg=16'h00F0` → rows 0 and 7 both = 00F0 on the same edge.
- With `VFD_DECAY_EN` and PERSIST=8: commit row3, then `grid=0`; pulse `tick` 8 times → row3 clears on the 8th tick, `lit[3]` drops, `changed` pulses. Without the macro, row3 is retained after 8 ticks.
- `tick` during LOCK on row5 → row5 pc stays at PERSIST and does not decrement. Assert `reset` mid-LOCK → all outputs 0 asynchronously.
